// File: rtl/generateproof_deadlock_watchdog_pkg.sv
// Shared types and defaults for the deadlock watchdog slice.
package generateproof_deadlock_watchdog_pkg;

    // Watchdog FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WATCH   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_REPORT  = 3'd3,
        ST_HOLD    = 3'd4
    } wd_state_e;

    // Default parameter values
    localparam int DEF_NUM_MON        = 8;
    localparam int DEF_CONFIRM_CYCLES = 16;
    localparam int DEF_STAMP_W        = 32;

    // Width of the saturating aborted-confirmation counter
    localparam int GLITCH_W = 16;

endpackage

// File: rtl/generateproof_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a mask (0 when empty).
module generateproof_lowest_set_idx #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit wins
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) idx_o = i[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/generateproof_deadlock_watchdog.sv
// Deadlock watchdog: confirms a persistent block condition from the
// per-process monitors, then raises a stamped report and a sticky flag.
module generateproof_deadlock_watchdog
    import generateproof_deadlock_watchdog_pkg::*;
#(
    parameter int NUM_MON        = DEF_NUM_MON,
    parameter int CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
    parameter int STAMP_W        = DEF_STAMP_W
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           enable,
    input  logic [NUM_MON-1:0]                             mon_block,
    input  logic                                           clear,
    input  logic                                           rpt_ready,
    output logic                                           rpt_valid,
    output logic [((NUM_MON > 1) ? $clog2(NUM_MON) : 1)-1:0] rpt_idx,
    output logic [STAMP_W-1:0]                             rpt_stamp,
    output logic                                           deadlock,
    output logic [GLITCH_W-1:0]                            glitch_cnt
);

    localparam int IDX_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CONFIRM_CYCLES);

    wd_state_e           state_q, state_d;
    logic [STAMP_W-1:0]  cyc_q;
    logic [NUM_MON-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STAMP_W-1:0]  stamp_q, stamp_d;
    logic [IDX_W-1:0]    rpt_idx_q, rpt_idx_d;
    logic [STAMP_W-1:0]  rpt_stamp_q, rpt_stamp_d;
    logic                rpt_valid_q, rpt_valid_d;
    logic                deadlock_q, deadlock_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    logic [NUM_MON-1:0]  hit;
    logic [CNT_W-1:0]    count_inc;
    logic [IDX_W-1:0]    hit_idx;

    // Processes still blocked this cycle among those blocked since the first sample
    assign hit       = mon_block & mask_q;
    assign count_inc = count_q + CNT_W'(1);

    // The reported index comes from the narrowed mask at the confirming edge
    generateproof_lowest_set_idx #(
        .N     (NUM_MON),
        .IDX_W (IDX_W)
    ) u_lowest (
        .mask_i (hit),
        .idx_o  (hit_idx)
    );

    // Next-state and datapath updates for the watchdog FSM
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        count_d     = count_q;
        stamp_d     = stamp_q;
        rpt_idx_d   = rpt_idx_q;
        rpt_stamp_d = rpt_stamp_q;
        rpt_valid_d = rpt_valid_q;
        deadlock_d  = deadlock_q;
        glitch_d    = glitch_q;

        unique case (state_q)
            ST_IDLE: begin
                mask_d  = '0;
                count_d = '0;
                if (enable) state_d = ST_WATCH;
            end
            ST_WATCH: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    count_d = '0;
                end else if (|mon_block) begin
                    state_d = ST_CONFIRM;
                    mask_d  = mon_block;
                    count_d = CNT_W'(1);
                    stamp_d = cyc_q;
                end
            end
            ST_CONFIRM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    mask_d  = '0;
                    count_d = '0;
                end else if (|hit) begin
                    mask_d  = hit;
                    count_d = count_inc;
                    if (count_inc == CNT_DONE) begin
                        state_d     = ST_REPORT;
                        rpt_idx_d   = hit_idx;
                        rpt_stamp_d = stamp_q;
                        rpt_valid_d = 1'b1;
                        deadlock_d  = 1'b1;
                    end
                end else begin
                    // Block vanished before confirmation: count it as a glitch
                    state_d = ST_WATCH;
                    mask_d  = '0;
                    count_d = '0;
                    if (glitch_q != '1) glitch_d = glitch_q + GLITCH_W'(1);
                end
            end
            ST_REPORT: begin
                if (rpt_valid_q && rpt_ready) begin
                    state_d     = ST_HOLD;
                    rpt_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (clear) begin
                    state_d    = enable ? ST_WATCH : ST_IDLE;
                    deadlock_d = 1'b0;
                    mask_d     = '0;
                    count_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; the cycle counter free-runs and wraps
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            mask_q      <= '0;
            count_q     <= '0;
            stamp_q     <= '0;
            rpt_idx_q   <= '0;
            rpt_stamp_q <= '0;
            rpt_valid_q <= 1'b0;
            deadlock_q  <= 1'b0;
            glitch_q    <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_q + STAMP_W'(1);
            mask_q      <= mask_d;
            count_q     <= count_d;
            stamp_q     <= stamp_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_stamp_q <= rpt_stamp_d;
            rpt_valid_q <= rpt_valid_d;
            deadlock_q  <= deadlock_d;
            glitch_q    <= glitch_d;
        end
    end

    assign rpt_valid  = rpt_valid_q;
    assign rpt_idx    = rpt_idx_q;
    assign rpt_stamp  = rpt_stamp_q;
    assign deadlock   = deadlock_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_generateproof_deadlock_watchdog.sv
// Directed bench for the deadlock watchdog. Inputs change and outputs are
// sampled on the falling edge; "cycle n" is the cycle whose counter value is n.
module tb_generateproof_deadlock_watchdog;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  mon_block;
    logic        clear;
    logic        rpt_ready;
    logic        rpt_valid;
    logic [2:0]  rpt_idx;
    logic [31:0] rpt_stamp;
    logic        deadlock;
    logic [15:0] glitch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    generateproof_deadlock_watchdog dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mon_block  (mon_block),
        .clear      (clear),
        .rpt_ready  (rpt_ready),
        .rpt_valid  (rpt_valid),
        .rpt_idx    (rpt_idx),
        .rpt_stamp  (rpt_stamp),
        .deadlock   (deadlock),
        .glitch_cnt (glitch_cnt)
    );

    task automatic step();
        @(negedge clock);
    endtask

    // Leaves the bench in cycle 0 with all inputs idle
    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; mon_block = '0; clear = 1'b0; rpt_ready = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mon_block = 8'hFF; clear = 1'b1; rpt_ready = 1'b1;
        repeat (3) step();
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL reset_deadlock: got %0b want 0", deadlock); end
        total++; if (rpt_idx !== 3'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", rpt_idx); end
        total++; if (rpt_stamp !== 32'd0) begin bad++; $display("FAIL reset_stamp: got %0h want 0", rpt_stamp); end
        total++; if (glitch_cnt !== 16'd0) begin bad++; $display("FAIL reset_glitch: got %0d want 0", glitch_cnt); end
    endtask

    task automatic test_basic();
        do_reset();
        enable = 1'b1;
        repeat (10) step();                 // cycle 10
        mon_block = 8'h08;
        repeat (15) step();                 // cycle 25
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %0b want 0", rpt_valid); end
        step();                             // cycle 26
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_idx !== 3'd3) begin bad++; $display("FAIL basic_idx: got %0d want 3", rpt_idx); end
        total++; if (rpt_stamp !== 32'd10) begin bad++; $display("FAIL basic_stamp: got %0d want 10", rpt_stamp); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL basic_deadlock: got %0b want 1", deadlock); end
        rpt_ready = 1'b1;
        step();                             // cycle 27: HOLD
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL basic_hs_valid: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL basic_hold_dl: got %0b want 1", deadlock); end
        rpt_ready = 1'b0; mon_block = '0; clear = 1'b1;
        step();
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL basic_clear_dl: got %0b want 0", deadlock); end
        clear = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        enable = 1'b1;
        step();                             // cycle 1, WATCH
        mon_block = 8'h08;
        repeat (5) step();                  // cycle 6, count=5
        mon_block = 8'h00;
        step();                             // cycle 7, back in WATCH
        total++; if (glitch_cnt !== 16'd1) begin bad++; $display("FAIL glitch_cnt: got %0d want 1", glitch_cnt); end
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %0b want 0", rpt_valid); end
        // From WATCH a fresh block reports 16 cycles later; from IDLE it would take 17
        mon_block = 8'h04;
        repeat (15) step();                 // cycle 22
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL glitch_early: got %0b want 0", rpt_valid); end
        step();                             // cycle 23
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL glitch_rewatch: got %0b want 1", rpt_valid); end
        total++; if (rpt_stamp !== 32'd7) begin bad++; $display("FAIL glitch_stamp: got %0d want 7", rpt_stamp); end
        total++; if (rpt_idx !== 3'd2) begin bad++; $display("FAIL glitch_idx: got %0d want 2", rpt_idx); end
        total++; if (glitch_cnt !== 16'd1) begin bad++; $display("FAIL glitch_keep: got %0d want 1", glitch_cnt); end
    endtask

    task automatic test_narrow();
        do_reset();
        enable = 1'b1;
        step();                             // cycle 1
        mon_block = 8'h30;
        repeat (4) step();                  // cycle 5
        mon_block = 8'h20;
        repeat (11) step();                 // cycle 16
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL narrow_early: got %0b want 0", rpt_valid); end
        step();                             // cycle 17
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL narrow_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_idx !== 3'd5) begin bad++; $display("FAIL narrow_idx: got %0d want 5", rpt_idx); end
        total++; if (rpt_stamp !== 32'd1) begin bad++; $display("FAIL narrow_stamp: got %0d want 1", rpt_stamp); end
    endtask

    task automatic test_hold_report();
        do_reset();
        enable = 1'b1;
        step();                             // cycle 1
        mon_block = 8'h02;
        repeat (16) step();                 // cycle 17, REPORT
        // Inputs that must not disturb REPORT
        mon_block = 8'h80; enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL hold_valid k=%0d: got %0b want 1", k, rpt_valid); end
            total++; if (rpt_idx !== 3'd1) begin bad++; $display("FAIL hold_idx k=%0d: got %0d want 1", k, rpt_idx); end
            total++; if (rpt_stamp !== 32'd1) begin bad++; $display("FAIL hold_stamp k=%0d: got %0d want 1", k, rpt_stamp); end
            total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL hold_dl k=%0d: got %0b want 1", k, deadlock); end
            clear = (k == 3);
            step();
        end
        clear = 1'b0;                       // cycle 24
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL hold_still: got %0b want 1", rpt_valid); end
        rpt_ready = 1'b1;
        step();                             // cycle 25, HOLD
        rpt_ready = 1'b0;
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL hold_hs: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL hold_dl25: got %0b want 1", deadlock); end
        step();                             // cycle 26
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL hold_once: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL hold_dl26: got %0b want 1", deadlock); end
        clear = 1'b1;
        step();                             // cycle 27, IDLE
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL hold_clear: got %0b want 0", deadlock); end
        clear = 1'b0; enable = 1'b1;
        // IDLE -> WATCH at end of 27, block sampled at end of 28
        repeat (17) step();                 // cycle 44
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL hold_idle_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_stamp !== 32'd28) begin bad++; $display("FAIL hold_idle_stamp: got %0d want 28", rpt_stamp); end
        total++; if (rpt_idx !== 3'd7) begin bad++; $display("FAIL hold_idle_idx: got %0d want 7", rpt_idx); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1; rpt_ready = 1'b1;
        step();                             // cycle 1
        mon_block = 8'h01;
        repeat (15) step();                 // cycle 16
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL b2b_early: got %0b want 0", rpt_valid); end
        step();                             // cycle 17
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_idx !== 3'd0) begin bad++; $display("FAIL b2b_idx: got %0d want 0", rpt_idx); end
        step();                             // cycle 18
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL b2b_single: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b1) begin bad++; $display("FAIL b2b_dl: got %0b want 1", deadlock); end
        step();                             // cycle 19
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_second: got %0b want 0", rpt_valid); end
        rpt_ready = 1'b0;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        step();                             // cycle 1
        mon_block = 8'h08;
        repeat (9) step();                  // cycle 10, count=9
        enable = 1'b0;
        step();                             // cycle 11, IDLE
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL drop_valid: got %0b want 0", rpt_valid); end
        total++; if (glitch_cnt !== 16'd0) begin bad++; $display("FAIL drop_glitch: got %0d want 0", glitch_cnt); end
        repeat (19) step();                 // cycle 30
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL drop_idle: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL drop_dl: got %0b want 0", deadlock); end
        enable = 1'b1;
        repeat (16) step();                 // cycle 46
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL drop_re_early: got %0b want 0", rpt_valid); end
        step();                             // cycle 47
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL drop_re_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_stamp !== 32'd31) begin bad++; $display("FAIL drop_re_stamp: got %0d want 31", rpt_stamp); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        enable = 1'b1;
        step();                             // cycle 1, WATCH
        force dut.cyc_q = 32'hFFFF_FFFE;
        step();
        force dut.cyc_q = 32'hFFFF_FFFF;
        mon_block = 8'h08;
        step();                             // block sampled at 0xFFFFFFFF
        release dut.cyc_q;
        repeat (15) step();
        total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %0b want 1", rpt_valid); end
        total++; if (rpt_stamp !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_stamp: got %0h want ffffffff", rpt_stamp); end
        total++; if (rpt_idx !== 3'd3) begin bad++; $display("FAIL wrap_idx: got %0d want 3", rpt_idx); end
        // Reset mid-REPORT with every other input pushing the other way
        reset = 1'b1; clear = 1'b1; rpt_ready = 1'b0; mon_block = 8'hFF;
        step();
        total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL rst_rpt_valid: got %0b want 0", rpt_valid); end
        total++; if (deadlock !== 1'b0) begin bad++; $display("FAIL rst_rpt_dl: got %0b want 0", deadlock); end
        total++; if (rpt_idx !== 3'd0) begin bad++; $display("FAIL rst_rpt_idx: got %0d want 0", rpt_idx); end
        total++; if (rpt_stamp !== 32'd0) begin bad++; $display("FAIL rst_rpt_stamp: got %0h want 0", rpt_stamp); end
        total++; if (glitch_cnt !== 16'd0) begin bad++; $display("FAIL rst_rpt_glitch: got %0d want 0", glitch_cnt); end
        reset = 1'b0; clear = 1'b0; mon_block = '0; enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mon_block = '0; clear = 1'b0; rpt_ready = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_narrow();
        test_hold_report();
        test_back_to_back();
        test_enable_drop();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/generateproof_deadlock_watchdog.md
GENERATEPROOF_DEADLOCK_WATCHDOG -- requirements
Module: generateproof_deadlock_watchdog

Interface
REQ-001 SHALL take parameter NUM_MON, default 8: number of per-process block inputs.
REQ-002 SHALL take parameter CONFIRM_CYCLES, default 16: consecutive blocked cycles needed to declare deadlock; legal range 2..65535.
REQ-003 SHALL take parameter STAMP_W, default 32: width of the timestamp.
REQ-004 SHALL have port clock, input, 1, the block clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, arms the watchdog.
REQ-007 SHALL have port mon_block, input, NUM_MON, block flags from the per-process deadlock monitors.
REQ-008 SHALL have port clear, input, 1, releases a latched deadlock.
REQ-009 SHALL have port rpt_ready, input, 1, report consumer ready.
REQ-010 SHALL have port rpt_valid, output, 1, report available.
REQ-011 SHALL have port rpt_idx, output, clog2(NUM_MON), index of the blocked process.
REQ-012 SHALL have port rpt_stamp, output, STAMP_W, cycle stamp of the first blocked sample.
REQ-013 SHALL have port deadlock, output, 1, sticky deadlock level.
REQ-014 SHALL have port glitch_cnt, output, 16, count of aborted confirmations.

Function
REQ-015 SHALL run a free-running cycle counter: 0 after reset, +1 every clock, wraps modulo 2^STAMP_W.
REQ-016 SHALL implement FSM states IDLE, WATCH, CONFIRM, REPORT, HOLD.
REQ-017 IDLE: go to WATCH when enable=1.
REQ-018 WATCH: when mon_block!=0, load mask=mon_block, count=1, stamp=cycle counter, and go to CONFIRM.
REQ-019 CONFIRM: when (mon_block & mask)!=0, update mask&=mon_block and count+=1.
REQ-020 CONFIRM: when count reaches CONFIRM_CYCLES, go to REPORT with rpt_idx = lowest set bit of the final mask.
REQ-021 CONFIRM: when (mon_block & mask)==0, return to WATCH, clear count, and increment glitch_cnt (saturating at 0xFFFF).
REQ-022 A mon_block asserted steadily from the first sampling edge SHALL make rpt_valid rise exactly CONFIRM_CYCLES cycles later.
REQ-023 enable=0 in WATCH or CONFIRM SHALL force IDLE on the next edge, clearing mask and count.
REQ-024 enable SHALL be ignored in REPORT and HOLD.
REQ-025 REPORT: rpt_valid=1 and deadlock=1; rpt_idx and rpt_stamp SHALL stay stable until rpt_valid&rpt_ready; the handshake SHALL move the FSM to HOLD.
REQ-026 clear in REPORT SHALL be ignored.
REQ-027 HOLD: rpt_valid=0 and deadlock stays 1; on clear=1 go to WATCH if enable=1, else IDLE; deadlock=0 from the next cycle.
REQ-028 rpt_ready=1 together with the REPORT entry edge SHALL still give exactly one rpt_valid cycle.
REQ-029 deadlock SHALL be driven from a register, not from combinational logic.

Reset
REQ-030 Reset SHALL give: state IDLE, rpt_valid=0, deadlock=0, rpt_idx=0, rpt_stamp=0, glitch_cnt=0, cycle counter=0, mask=0, count=0.
REQ-031 Reset asserted in any state, including mid-REPORT, SHALL override all other inputs and drop every output on the next edge.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default parameter constants and the glitch_cnt width.
REQ-033 A single sub-module, generateproof_lowest_set_idx (priority encoder from mask to index), SHALL be instantiated; everything else stays flat.

Verification
REQ-034 Bench SHALL drive enable=1, mon_block=0x08 held from cycle 10 -> rpt_valid rises at cycle 26 with rpt_idx=3 and rpt_stamp=10.
REQ-035 Bench SHALL drive mon_block=0x08 for 5 cycles, then 0x00 -> no report, glitch_cnt=1, FSM back in WATCH.
REQ-036 Bench SHALL drive mon_block=0x30 for 4 cycles, then 0x20 held -> rpt_idx=5 (mask narrowed).
REQ-037 Bench SHALL hold rpt_ready=0 for 7 cycles in REPORT -> idx and stamp stable; one handshake; deadlock stays 1 until clear; clear with enable=0 -> IDLE.
REQ-038 Bench SHALL drop enable mid-CONFIRM (count=9) -> IDLE next cycle, no report, glitch_cnt unchanged.
REQ-039 Bench SHALL start the cycle counter at 0xFFFFFFFE and block at 0xFFFFFFFF -> rpt_stamp=0xFFFFFFFF; also assert reset during REPORT -> all outputs 0 next cycle.
